// File: rtl/supersample_stream.sv
// Handshaked chroma upsampler: buffers one NxN block, emits 1/2/4 beats.
// Build option SUPERSAMPLE_FANCY_EN selects triangle interpolation for chroma.
`timescale 1ns/1ps
module supersample_stream #(
  parameter int DATA_W = 8,
  parameter int N      = 8,
  parameter int CH     = 3,
  parameter int CH_W   = $clog2(CH+1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_in,
  output logic                               ready_in,
  input  logic [CH_W-1:0]                    ch_in,
  input  logic [1:0]                         mode_in,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]    block_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N-1:0][N-1:0][DATA_W-1:0]    out_block,
  output logic [CH_W-1:0]                    out_ch,
  output logic [1:0]                         out_idx,
  output logic                               out_last
);

  localparam int IW = $clog2(N);
  localparam int SW = DATA_W + 4;

  localparam logic [1:0] M11 = 2'd0;
  localparam logic [1:0] M21 = 2'd1;
  localparam logic [1:0] M22 = 2'd2;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                            state_q;
  logic [1:0]                        k_q;
  logic [1:0]                        mode_q;
  logic [CH_W-1:0]                   ch_q;
  logic [N-1:0][N-1:0][DATA_W-1:0]   buf_q;

  logic [1:0] mode_d;
  logic [1:0] last_k;
  logic       hs;
  logic       accept;
  logic       take;
  logic       qr;
  logic       qc;

  // Luma is never resampled; mode 11 behaves like 4:2:0.
  always_comb begin
    mode_d = M22;
    if (ch_in == '0 || mode_in == 2'b00)
      mode_d = M11;
    else if (mode_in == 2'b01)
      mode_d = M21;
  end

  // Index of the final beat for the latched mode.
  always_comb begin
    unique case (mode_q)
      M22:     last_k = 2'd3;
      M21:     last_k = 2'd1;
      default: last_k = 2'd0;
    endcase
  end

  assign out_valid = (state_q == S_EMIT);
  assign out_last  = out_valid && (k_q == last_k);
  assign out_ch    = ch_q;
  assign out_idx   = (mode_q == M22) ? k_q :
                     (mode_q == M21) ? {1'b0, k_q[0]} : 2'b00;
  assign qr        = out_idx[1];
  assign qc        = out_idx[0];

  assign hs       = out_valid && out_ready;
  assign ready_in = (state_q == S_IDLE) || (hs && out_last);
  assign accept   = valid_in && ready_in;
  assign take     = accept && (ch_in < CH_W'(CH));

  // Beat sequencer; a new block can be taken on the last beat's handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      mode_q  <= M11;
      ch_q    <= '0;
      buf_q   <= '0;
    end else begin
      if (take) begin
        buf_q   <= block_in;
        ch_q    <= ch_in;
        mode_q  <= mode_d;
        k_q     <= 2'd0;
        state_q <= S_EMIT;
      end else if (hs) begin
        if (out_last) begin
          state_q <= S_IDLE;
          k_q     <= 2'd0;
        end else begin
          k_q <= k_q + 2'd1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_r
    for (genvar gj = 0; gj < N; gj++) begin : g_c
      logic [IW-1:0]     sr;
      logic [IW-1:0]     sc;
      logic [DATA_W-1:0] pix;

      // Source pixel in the buffer for this output position.
      always_comb begin
        sr = IW'(gi);
        sc = IW'(gj);
        if (mode_q == M22)
          sr = qr ? IW'(N/2 + gi/2) : IW'(gi/2);
        if (mode_q != M11)
          sc = qc ? IW'(N/2 + gj/2) : IW'(gj/2);
      end

`ifdef SUPERSAMPLE_FANCY_EN
      logic [IW-1:0] nr;
      logic [IW-1:0] nc;
      logic [SW-1:0] ea;
      logic [SW-1:0] eb;
      logic [SW-1:0] ec;
      logic [SW-1:0] ed;
      logic [SW-1:0] s2;
      logic [SW-1:0] s4;

      // Nearest other source sample, clamped at the block edge.
      always_comb begin
        if (gj % 2 == 1)
          nc = (sc == IW'(N-1)) ? sc : sc + IW'(1);
        else
          nc = (sc == '0) ? sc : sc - IW'(1);
        if (gi % 2 == 1)
          nr = (sr == IW'(N-1)) ? sr : sr + IW'(1);
        else
          nr = (sr == '0) ? sr : sr - IW'(1);
      end

      assign ea = SW'(buf_q[sr][sc]);
      assign eb = SW'(buf_q[sr][nc]);
      assign ec = SW'(buf_q[nr][sc]);
      assign ed = SW'(buf_q[nr][nc]);
      assign s2 = ea + ea + ea + eb + SW'(2);
      assign s4 = SW'(9) * ea + SW'(3) * eb
                + SW'(3) * ec + ed + SW'(8);

      // Weighted blend; the weights sum to a power of two.
      always_comb begin
        unique case (mode_q)
          M21:     pix = DATA_W'(s2 >> 2);
          M22:     pix = DATA_W'(s4 >> 4);
          default: pix = buf_q[sr][sc];
        endcase
      end
`else
      assign pix = buf_q[sr][sc];
`endif

      assign out_block[gi][gj] = pix;
    end
  end

endmodule

// File: tb/tb_supersample_stream.sv
// Scoreboard bench for supersample_stream.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_supersample_stream;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int CH = 3;
  localparam int CW = 2;
  localparam int XW = N*N*DW + 8;

  typedef logic [N-1:0][N-1:0][DW-1:0] blk_t;
  typedef struct packed {
    logic [CW-1:0] ch;
    logic [1:0]    idx;
    logic          last;
    blk_t          blk;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic          ready_in;
  logic [CW-1:0] ch_in;
  logic [1:0]    mode_in;
  blk_t          block_in;
  logic          out_valid;
  logic          out_ready;
  blk_t          out_block;
  logic [CW-1:0] out_ch;
  logic [1:0]    out_idx;
  logic          out_last;

  supersample_stream #(
    .DATA_W(DW), .N(N), .CH(CH), .CH_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_in(ready_in),
    .ch_in(ch_in), .mode_in(mode_in), .block_in(block_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .out_ch(out_ch),
    .out_idx(out_idx), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  beat_t sb[$];
  int    hs_cyc[$];
  int    total  = 0;
  int    passed = 0;

  task automatic chk(input string nm, input logic [XW-1:0] act,
                     input logic [XW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic blk_t model(input blk_t s, input int m, input int idx);
    blk_t r;
    int qr, qc, sr, sc, t;
`ifdef SUPERSAMPLE_FANCY_EN
    int nr, nc, a, b, c, d;
`endif
    qr = idx / 2;
    qc = idx % 2;
    r  = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (m == 0) begin
          r[i][j] = s[i][j];
        end else begin
          sr = (m == 2) ? qr*N/2 + i/2 : i;
          sc = qc*N/2 + j/2;
`ifdef SUPERSAMPLE_FANCY_EN
          nc = ((qc*N + j) % 2 == 1) ? sc + 1 : sc - 1;
          if (nc < 0) nc = 0;
          if (nc > N-1) nc = N-1;
          nr = ((qr*N + i) % 2 == 1) ? sr + 1 : sr - 1;
          if (nr < 0) nr = 0;
          if (nr > N-1) nr = N-1;
          a = int'(s[sr][sc]);
          b = int'(s[sr][nc]);
          c = int'(s[nr][sc]);
          d = int'(s[nr][nc]);
          if (m == 1) t = (3*a + b + 2) >> 2;
          else        t = (9*a + 3*b + 3*c + d + 8) >> 4;
`else
          t = int'(s[sr][sc]);
`endif
          r[i][j] = t[7:0];
        end
      end
    end
    return r;
  endfunction

  task automatic push_block(input logic [1:0] ch, input logic [1:0] md,
                            input blk_t b);
    int m, nb;
    beat_t e;
    if (int'(ch) >= CH) return;
    m  = (ch == 0 || md == 2'b00) ? 0 : (md == 2'b01 ? 1 : 2);
    nb = (m == 0) ? 1 : (m == 1 ? 2 : 4);
    for (int k = 0; k < nb; k++) begin
      e.ch   = ch;
      e.idx  = (m == 0) ? 2'd0 : 2'(k);
      e.last = (k == nb-1);
      e.blk  = model(b, m, k);
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [1:0] md,
                      input blk_t b, input bit keep, output int acc);
    bit got;
    got = 0;
    acc = -1;
    ch_in    = ch;
    mode_in  = md;
    block_in = b;
    valid_in = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (ready_in) begin
        got = 1;
        acc = cyc;
        push_block(ch, md, b);
      end
    end
    if (!got) begin
      total++;
      $display("FAIL accept_timeout ch=%0d", ch);
    end
    @(posedge clk);
    #1;
    if (!keep) valid_in = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain_timeout left=%0d required=0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each accepted beat and hold-stability under stall.
  logic [XW-1:0] held;
  bit            stall_prev = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (stall_prev)
        chk("stall_hold",
            {out_block, out_ch, out_idx, out_last}, held);
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat idx=%0d required=none", out_idx);
        end else begin
          e = sb.pop_front();
          chk("beat_ch", out_ch, e.ch);
          chk("beat_idx", out_idx, e.idx);
          chk("beat_last", out_last, e.last);
          chk("beat_blk", out_block, e.blk);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_block, out_ch, out_idx, out_last};
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  blk_t b0, bf;
  int   acc, acc_y, n0, seen;
  int   tmp;

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tmp = 8*i + j;
        b0[i][j] = tmp[7:0];
        tmp = (i == 0) ? 40*j : 8*i + j;
        bf[i][j] = tmp[7:0];
      end

    rst = 1'b1;
    valid_in = 1'b0;
    ch_in = '0;
    mode_in = '0;
    block_in = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ready_in", ready_in, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_block", out_block, 0);
    @(posedge clk);
    #1;

    // Y block: single pass-through beat right after accept.
    send(2'd0, 2'b10, b0, 0, acc);
    @(negedge clk);
    chk("y_valid_next", out_valid, 1);
    chk("y_passthru", out_block, b0);
    chk("y_last", out_last, 1);
    drain();

    // Cb 4:2:0: four beats, check idx3 corner pixels.
    send(2'd1, 2'b10, b0, 0, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cb_idx3", out_idx, 3);
    chk("cb_idx3_last", out_last, 1);
`ifdef SUPERSAMPLE_FANCY_EN
    chk("cb_idx3_p00", out_block[0][0], 34);
`else
    chk("cb_idx3_p00", out_block[0][0], 36);
`endif
    chk("cb_idx3_p77", out_block[7][7], 63);
    drain();

    // Cr 4:2:2 with stalls on the second beat.
    send(2'd2, 2'b01, b0, 0, acc);
    @(negedge clk);
    chk("cr_busy_idx0", ready_in, 0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("cr_stall1_ready", ready_in, 0);
    chk("cr_idx1_p50", out_block[5][0], 44);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cr_stall2_ready", ready_in, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("cr_last_ready", ready_in, 1);
    drain();

    // Back-to-back Cb then Y with valid held high.
    n0 = hs_cyc.size();
    send(2'd1, 2'b10, b0, 1, acc);
    send(2'd0, 2'b00, b0, 0, acc_y);
    drain();
    chk("b2b_beats", hs_cyc.size() - n0, 5);
    if (hs_cyc.size() - n0 >= 5) begin
      chk("b2b_span", hs_cyc[n0+4] - hs_cyc[n0], 4);
      chk("b2b_overlap", acc_y, hs_cyc[n0+3]);
    end

    // Out-of-range channel: accepted and dropped.
    send(2'd3, 2'b10, b0, 0, acc);
    chk("bad_ch_accepted", acc >= 0, 1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("bad_ch_no_beat", seen, 0);
    @(posedge clk);
    #1;

    // Reset during the Cb idx1 beat.
    send(2'd1, 2'b10, b0, 0, acc);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_idx1", out_idx, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", ready_in, 1);
    chk("mid_rst_block", out_block, 0);
    chk("mid_rst_left", sb.size(), 3);
    sb.delete();
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(2'd0, 2'b10, b0, 0, acc);
    drain();

`ifdef SUPERSAMPLE_FANCY_EN
    // Interpolated 4:2:2 first row, left edge clamped.
    out_ready = 1'b0;
    send(2'd1, 2'b01, bf, 0, acc);
    @(negedge clk);
    chk("fancy_p00", out_block[0][0], 0);
    chk("fancy_p01", out_block[0][1], 10);
    chk("fancy_p02", out_block[0][2], 30);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
`else
    // Replicated 4:2:2 first row.
    out_ready = 1'b0;
    send(2'd1, 2'b01, bf, 0, acc);
    @(negedge clk);
    chk("rep_p01", out_block[0][1], 0);
    chk("rep_p02", out_block[0][2], 40);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
